// File: rtl/sdnet_port_arbiter.sv
// Packet-granular round-robin merge of four AXI-Stream rx ports.
// Tags each packet with its source port and counts packets per port.
module sdnet_port_arbiter #(
    parameter int DATA_W = 64,
    parameter int NPORTS = 4,
    parameter int CNT_W  = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NPORTS-1:0]          port_enable,
    input  logic [NPORTS*DATA_W-1:0]   s_axis_tdata,
    input  logic [NPORTS*DATA_W/8-1:0] s_axis_tkeep,
    input  logic [NPORTS-1:0]          s_axis_tlast,
    input  logic [NPORTS-1:0]          s_axis_tvalid,
    output logic [NPORTS-1:0]          s_axis_tready,
    output logic [DATA_W-1:0]          m_axis_tdata,
    output logic [DATA_W/8-1:0]        m_axis_tkeep,
    output logic                       m_axis_tlast,
    output logic [1:0]                 m_axis_tuser,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic [NPORTS*CNT_W-1:0]    pkt_cnt,
    output logic                       active
);
    localparam int KEEP_W = DATA_W / 8;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t            state_q, state_d;
    logic [1:0]        grant_q, grant_d;
    logic [1:0]        last_grant_q, last_grant_d;
    logic [CNT_W-1:0]  cnt_q [NPORTS];
    logic [CNT_W-1:0]  cnt_d [NPORTS];

    logic [NPORTS-1:0] req;
    logic [1:0]        pick;
    logic [1:0]        idx;
    logic              found;
    logic              busy;
    logic [DATA_W-1:0] sel_data;
    logic [KEEP_W-1:0] sel_keep;
    logic              sel_last;
    logic              sel_valid;
    logic              xfer_last;

    assign req       = s_axis_tvalid & port_enable;
    assign busy      = (state_q == BUSY);
    assign sel_data  = s_axis_tdata[int'(grant_q)*DATA_W +: DATA_W];
    assign sel_keep  = s_axis_tkeep[int'(grant_q)*KEEP_W +: KEEP_W];
    assign sel_last  = s_axis_tlast[grant_q];
    assign sel_valid = s_axis_tvalid[grant_q];
    assign xfer_last = busy & sel_valid & m_axis_tready & sel_last;

    // Search starts one past the previous winner so every port gets a turn.
    always_comb begin
        pick  = last_grant_q;
        idx   = '0;
        found = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            idx = last_grant_q + 2'(i);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= 2'd3;
            for (int i = 0; i < NPORTS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            for (int i = 0; i < NPORTS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    grant_d = pick;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (xfer_last) begin
                    last_grant_d = grant_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        for (int i = 0; i < NPORTS; i++) begin
            cnt_d[i] = cnt_q[i];
        end
        if (xfer_last) begin
            cnt_d[grant_q] = cnt_q[grant_q] + CNT_W'(1);
        end
    end

    always_comb begin
        s_axis_tready = '0;
        m_axis_tdata  = '0;
        m_axis_tkeep  = '0;
        m_axis_tlast  = 1'b0;
        m_axis_tuser  = '0;
        m_axis_tvalid = 1'b0;
        active        = 1'b0;
        if (busy) begin
            s_axis_tready[grant_q] = m_axis_tready;
            m_axis_tdata           = sel_data;
            m_axis_tkeep           = sel_keep;
            m_axis_tlast           = sel_last;
            m_axis_tuser           = grant_q;
            m_axis_tvalid          = sel_valid;
            active                 = 1'b1;
        end
    end

    always_comb begin
        for (int i = 0; i < NPORTS; i++) begin
            pkt_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
        end
    end

endmodule

// File: tb/tb_sdnet_port_arbiter.sv
// Directed bench for sdnet_port_arbiter: ordering, bubbles, backpressure,
// enables, counter wrap (narrow-counter instance) and mid-packet reset.
module tb_sdnet_port_arbiter;
    localparam int DW = 64;
    localparam int KW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset = 1'b1;
    logic [3:0]      port_enable = 4'hF;
    logic [4*DW-1:0] s_tdata = '0;
    logic [4*KW-1:0] s_tkeep = '0;
    logic [3:0]      s_tlast = '0;
    logic [3:0]      s_tvalid = '0;
    logic [3:0]      s_tready;
    logic [DW-1:0]   m_tdata;
    logic [KW-1:0]   m_tkeep;
    logic            m_tlast;
    logic [1:0]      m_tuser;
    logic            m_tvalid;
    logic            m_tready = 1'b1;
    logic [127:0]    pkt_cnt;
    logic            active;

    logic [3:0]      sm_tready;
    logic [DW-1:0]   sm_tdata;
    logic [KW-1:0]   sm_tkeep;
    logic            sm_tlast;
    logic [1:0]      sm_tuser;
    logic            sm_tvalid;
    logic [11:0]     sm_cnt;
    logic            sm_active;

    sdnet_port_arbiter u_dut (
        .clk(clk), .reset(reset), .port_enable(port_enable),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep),
        .s_axis_tlast(s_tlast), .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready),
        .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep),
        .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser),
        .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
        .pkt_cnt(pkt_cnt), .active(active)
    );

    // Narrow counters so the wrap can be reached in a few packets.
    sdnet_port_arbiter #(.CNT_W(3)) u_small (
        .clk(clk), .reset(reset), .port_enable(port_enable),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep),
        .s_axis_tlast(s_tlast), .s_axis_tvalid(s_tvalid),
        .s_axis_tready(sm_tready),
        .m_axis_tdata(sm_tdata), .m_axis_tkeep(sm_tkeep),
        .m_axis_tlast(sm_tlast), .m_axis_tuser(sm_tuser),
        .m_axis_tvalid(sm_tvalid), .m_axis_tready(m_tready),
        .pkt_cnt(sm_cnt), .active(sm_active)
    );

    logic [63:0] mem_d [4][64];
    logic [7:0]  mem_k [4][64];
    logic        mem_l [4][64];
    int          rd [4] = '{default: 0};
    int          wr [4] = '{default: 0};
    logic [3:0]  hs = '0;
    logic [3:0]  pe_next = 4'hF;
    logic        tr_toggle = 1'b0;
    int          cyc = 0;

    logic [63:0] cap_d [64];
    logic [7:0]  cap_k [64];
    logic        cap_l [64];
    logic [1:0]  cap_u [64];
    int          cap_c [64];
    int          ncap = 0;

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] pat(input int p, input int tag,
                                        input int b);
        return (64'(tag) << 32) | (64'(p) << 16) | 64'(b);
    endfunction

    task automatic add_pkt(input int p, input int n, input int tag);
        for (int b = 0; b < n; b++) begin
            mem_d[p][wr[p]] = pat(p, tag, b);
            mem_k[p][wr[p]] = (b == n - 1) ? 8'h0F : 8'hFF;
            mem_l[p][wr[p]] = (b == n - 1);
            wr[p]++;
        end
    endtask

    // Sources and sink: drive on negedge, sample the coming edge at +1.
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                if (hs[i] && rd[i] < wr[i]) rd[i]++;
            end
            port_enable = pe_next;
            m_tready = tr_toggle ? ~m_tready : 1'b1;
            for (int i = 0; i < 4; i++) begin
                if (rd[i] < wr[i]) begin
                    s_tvalid[i] = 1'b1;
                    s_tdata[i*DW +: DW] = mem_d[i][rd[i]];
                    s_tkeep[i*KW +: KW] = mem_k[i][rd[i]];
                    s_tlast[i] = mem_l[i][rd[i]];
                end else begin
                    s_tvalid[i] = 1'b0;
                    s_tdata[i*DW +: DW] = '0;
                    s_tkeep[i*KW +: KW] = '0;
                    s_tlast[i] = 1'b0;
                end
            end
            #1;
            hs = s_tvalid & s_tready;
            if (m_tvalid && m_tready && ncap < 64) begin
                cap_d[ncap] = m_tdata;
                cap_k[ncap] = m_tkeep;
                cap_l[ncap] = m_tlast;
                cap_u[ncap] = m_tuser;
                cap_c[ncap] = cyc;
                ncap++;
            end
            cyc++;
        end
    end

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic flush();
        for (int i = 0; i < 4; i++) begin
            rd[i] = 0;
            wr[i] = 0;
        end
        hs = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        flush();
        pe_next = 4'hF;
        tr_toggle = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        ncap = 0;
    endtask

    task automatic wait_ncap(input string tag, input int n,
                             input int budget);
        int c = 0;
        while (ncap < n && c < budget) begin
            tick();
            c++;
        end
        check(tag, 64'(ncap), 64'(n));
    endtask

    function automatic logic [63:0] cnt(input int p);
        return 64'(pkt_cnt[p*32 +: 32]);
    endfunction

    initial begin
        // Reset state
        tick();
        tick();
        tick();
        check("rst_tready", 64'(s_tready), 64'h0);
        check("rst_tvalid", 64'(m_tvalid), 64'h0);
        reset = 1'b0;
        tick();
        check("rst_tlast", 64'(m_tlast), 64'h0);
        check("rst_tuser", 64'(m_tuser), 64'h0);
        check("rst_active", 64'(active), 64'h0);
        check("rst_cnt", pkt_cnt[63:0] | pkt_cnt[127:64], 64'h0);

        // Four ports, one 3-beat packet each
        do_reset();
        for (int p = 0; p < 4; p++) add_pkt(p, 3, 1);
        wait_ncap("t1_beats", 12, 100);
        for (int k = 0; k < 12; k++) begin
            check("t1_user", 64'(cap_u[k]), 64'(k / 3));
            check("t1_data", cap_d[k], pat(k / 3, 1, k % 3));
            check("t1_last", 64'(cap_l[k]), 64'(k % 3 == 2));
            check("t1_keep", 64'(cap_k[k]),
                  (k % 3 == 2) ? 64'h0F : 64'hFF);
            if (k > 0) begin
                check("t1_gap", 64'(cap_c[k] - cap_c[k-1]),
                      (k % 3 == 0) ? 64'd2 : 64'd1);
            end
        end
        tick();
        for (int p = 0; p < 4; p++) check("t1_cnt", cnt(p), 64'd1);
        check("t1_idle", 64'(active), 64'h0);

        // Port 2 alone, five 1-beat packets
        do_reset();
        for (int j = 0; j < 5; j++) add_pkt(2, 1, 10 + j);
        wait_ncap("t2_beats", 5, 60);
        for (int k = 0; k < 5; k++) begin
            check("t2_user", 64'(cap_u[k]), 64'd2);
            check("t2_data", cap_d[k], pat(2, 10 + k, 0));
            if (k > 0) begin
                check("t2_gap", 64'(cap_c[k] - cap_c[k-1]), 64'd2);
            end
        end
        tick();
        check("t2_cnt0", cnt(0), 64'd0);
        check("t2_cnt1", cnt(1), 64'd0);
        check("t2_cnt2", cnt(2), 64'd5);
        check("t2_cnt3", cnt(3), 64'd0);

        // Port 0 must wait for port 1's packet to finish
        do_reset();
        add_pkt(1, 4, 20);
        wait_ncap("t3_start", 2, 20);
        add_pkt(0, 1, 21);
        tick();
        tick();
        check("t3_hold_vld", 64'(s_tvalid[0]), 64'h1);
        check("t3_hold_rdy", 64'(s_tready[0]), 64'h0);
        wait_ncap("t3_beats", 5, 30);
        for (int k = 0; k < 4; k++) begin
            check("t3_user1", 64'(cap_u[k]), 64'd1);
            check("t3_data1", cap_d[k], pat(1, 20, k));
        end
        check("t3_user0", 64'(cap_u[4]), 64'd0);
        check("t3_data0", cap_d[4], pat(0, 21, 0));
        check("t3_gap", 64'(cap_c[4] - cap_c[3]), 64'd2);

        // Downstream backpressure toggling during an 8-beat packet
        do_reset();
        tr_toggle = 1'b1;
        add_pkt(3, 8, 30);
        begin
            int c = 0;
            while (ncap < 8 && c < 40) begin
                tick();
                if (active) begin
                    check("t4_mirror", 64'(s_tready[3]), 64'(m_tready));
                    check("t4_others", 64'(s_tready[2:0]), 64'h0);
                end
                c++;
            end
        end
        check("t4_beats", 64'(ncap), 64'd8);
        tr_toggle = 1'b0;
        for (int k = 0; k < 8; k++) begin
            check("t4_data", cap_d[k], pat(3, 30, k));
            check("t4_last", 64'(cap_l[k]), 64'(k == 7));
        end
        tick();
        tick();
        check("t4_cnt3", cnt(3), 64'd1);

        // Port 2 masked by port_enable
        do_reset();
        pe_next = 4'b1011;
        for (int p = 0; p < 4; p++) add_pkt(p, 1, 40);
        wait_ncap("t5_beats", 3, 30);
        repeat (4) tick();
        check("t5_count", 64'(ncap), 64'd3);
        check("t5_u0", 64'(cap_u[0]), 64'd0);
        check("t5_u1", 64'(cap_u[1]), 64'd1);
        check("t5_u2", 64'(cap_u[2]), 64'd3);
        check("t5_rdy2", 64'(s_tready[2]), 64'h0);
        check("t5_cnt2", cnt(2), 64'd0);

        // Enable dropped mid-packet; packet still completes
        do_reset();
        add_pkt(0, 4, 50);
        wait_ncap("t5b_start", 1, 20);
        pe_next = 4'b1110;
        wait_ncap("t5b_beats", 4, 30);
        tick();
        tick();
        check("t5b_last", 64'(cap_l[3]), 64'h1);
        check("t5b_data", cap_d[3], pat(0, 50, 3));
        check("t5b_cnt0", cnt(0), 64'd1);

        // Wrap: 8 packets on port 0, 3-bit counter returns to 0
        do_reset();
        for (int j = 0; j < 8; j++) add_pkt(0, 1, 60 + j);
        wait_ncap("t6_beats", 8, 60);
        tick();
        tick();
        check("t6_cnt32", cnt(0), 64'd8);
        check("t6_wrap", 64'(sm_cnt[2:0]), 64'd0);
        check("t6_small1", 64'(sm_cnt[5:3]), 64'd0);

        // Reset mid-packet abandons the packet
        ncap = 0;
        add_pkt(1, 4, 70);
        wait_ncap("t7_start", 2, 20);
        reset = 1'b1;
        flush();
        tick();
        check("t7_tready", 64'(s_tready), 64'h0);
        check("t7_tvalid", 64'(m_tvalid), 64'h0);
        check("t7_active", 64'(active), 64'h0);
        check("t7_cnt0", cnt(0), 64'd0);
        reset = 1'b0;
        repeat (3) tick();
        check("t7_cnt1", cnt(1), 64'd0);
        check("t7_idle", 64'(m_tvalid), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
